// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control FSM for the RV64 datapath.
// Decodes the latched IR fields and sequences the datapath strobes through
// fetch, decode, execute, memory and write-back steps with a fixed memory read
// latency of MEM_WAIT cycles.
// Build macro TRAP_ILLEGAL_EN: when defined, an illegal instruction halts the
// FSM in TRAP with trap=1 until reset; otherwise it is retired as a NOP.
module controle_multiciclo #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i6_0,
    input  logic [2:0] i14_12,
    input  logic [6:0] i31_25,
    input  logic       AluIgual,
    output logic       PCwrite,
    output logic       SelMuxPC,
    output logic       LoadIR,
    output logic       RegWrite,
    output logic       loadRegA,
    output logic       loadRegB,
    output logic       loadRegAluOut,
    output logic       loadRegMemData,
    output logic       MemData_Read,
    output logic       MemWr,
    output logic       SelMux2,
    output logic [1:0] SelMux4,
    output logic [2:0] SelMuxMem,
    output logic [2:0] AluOperation,
    output logic       trap,
    output logic [4:0] estado
);

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_EXEC_R   = 5'd3,
        S_EXEC_I   = 5'd4,
        S_WB_ALU   = 5'd5,
        S_MEM_ADDR = 5'd6,
        S_LD_WAIT  = 5'd7,
        S_LD_WB    = 5'd8,
        S_ST       = 5'd9,
        S_BRANCH   = 5'd10,
        S_LUI      = 5'd11,
        S_JAL      = 5'd12,
        S_PC_INC   = 5'd13,
        S_ILLEGAL  = 5'd14,
        S_TRAP     = 5'd15
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // R-type ALU decode: returns {legal, AluOperation}
    function automatic logic [3:0] dec_r(input logic [2:0] f3, input logic f7b5);
        case ({f3, f7b5})
            4'b0000:          dec_r = {1'b1, 3'b001};
            4'b0001:          dec_r = {1'b1, 3'b010};
            4'b1110, 4'b1111: dec_r = {1'b1, 3'b011};
            4'b1000, 4'b1001: dec_r = {1'b1, 3'b100};
            4'b1100, 4'b1101: dec_r = {1'b1, 3'b101};
            default:          dec_r = {1'b0, 3'b000};
        endcase
    endfunction

    // I-type ALU decode: returns {legal, AluOperation}; no subtract form
    function automatic logic [3:0] dec_i(input logic [2:0] f3);
        case (f3)
            3'b000:  dec_i = {1'b1, 3'b001};
            3'b111:  dec_i = {1'b1, 3'b011};
            3'b100:  dec_i = {1'b1, 3'b100};
            3'b110:  dec_i = {1'b1, 3'b101};
            default: dec_i = {1'b0, 3'b000};
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic pc_write_q, pc_write_d, sel_pc_q, sel_pc_d, load_ir_q, load_ir_d;
    logic reg_write_q, reg_write_d, load_a_q, load_a_d, load_b_q, load_b_d;
    logic load_aluout_q, load_aluout_d, load_memdata_q, load_memdata_d;
    logic mem_read_q, mem_read_d, mem_wr_q, mem_wr_d, sel_mux2_q, sel_mux2_d;
    logic [1:0] sel_mux4_q, sel_mux4_d;
    logic [2:0] sel_mem_q, sel_mem_d, alu_op_q, alu_op_d;
    logic trap_q, trap_d;

    logic [3:0] r_dec_s, i_dec_s;
    logic       br_legal_s, taken_s;
    logic       unused_funct7_s;

    assign r_dec_s    = dec_r(i14_12, i31_25[5]);
    assign i_dec_s    = dec_i(i14_12);
    assign br_legal_s = (i14_12 == 3'b000) || (i14_12 == 3'b001);
    assign taken_s    = ((i14_12 == 3'b000) && AluIgual) ||
                        ((i14_12 == 3'b001) && !AluIgual);
    assign unused_funct7_s = ^{i31_25[6], i31_25[4:0]};

    // Next-state and wait-counter logic; the counter restarts on every state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DECODE: begin
                case (i6_0)
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_LD, OP_SD: state_d = S_MEM_ADDR;
                    OP_BR:        state_d = S_BRANCH;
                    OP_LUI:       state_d = S_LUI;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   state_d = r_dec_s[3] ? S_WB_ALU : S_ILLEGAL;
            S_EXEC_I:   state_d = i_dec_s[3] ? S_WB_ALU : S_ILLEGAL;
            S_WB_ALU:   state_d = S_PC_INC;
            S_MEM_ADDR: state_d = (i6_0 == OP_LD) ? S_LD_WAIT : S_ST;
            S_LD_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_LD_WB;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_LD_WB:    state_d = S_PC_INC;
            S_ST:       state_d = S_PC_INC;
            S_BRANCH: begin
                if (!br_legal_s) begin
                    state_d = S_ILLEGAL;
                end else if (taken_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_PC_INC;
                end
            end
            S_LUI:      state_d = S_PC_INC;
            S_JAL:      state_d = S_FETCH;
            S_PC_INC:   state_d = S_FETCH;
`ifdef TRAP_ILLEGAL_EN
            S_ILLEGAL:  state_d = S_TRAP;
            S_TRAP:     state_d = S_TRAP;
`else
            S_ILLEGAL:  state_d = S_FETCH;
            S_TRAP:     state_d = S_FETCH;
`endif
            default:    state_d = S_RESET;
        endcase
    end

    // Output decode from the upcoming state so every strobe leaves a flop
    always_comb begin
        pc_write_d = 1'b0;  sel_pc_d = 1'b0;  load_ir_d = 1'b0;  reg_write_d = 1'b0;
        load_a_d = 1'b0;  load_b_d = 1'b0;  load_aluout_d = 1'b0;  load_memdata_d = 1'b0;
        mem_read_d = 1'b0;  mem_wr_d = 1'b0;  sel_mux2_d = 1'b0;  sel_mux4_d = 2'b00;
        sel_mem_d = 3'b000;  alu_op_d = 3'b000;  trap_d = 1'b0;
        case (state_d)
            S_FETCH:  load_ir_d = (cnt_d == WAIT_LAST);
            S_DECODE: begin
                load_a_d = 1'b1;  load_b_d = 1'b1;  load_aluout_d = 1'b1;
                sel_mux4_d = 2'b11;  alu_op_d = 3'b001;
            end
            S_EXEC_R: begin
                sel_mux2_d = 1'b1;  load_aluout_d = 1'b1;  alu_op_d = r_dec_s[2:0];
            end
            S_EXEC_I: begin
                sel_mux2_d = 1'b1;  sel_mux4_d = 2'b10;  load_aluout_d = 1'b1;
                alu_op_d = i_dec_s[2:0];
            end
            S_WB_ALU: reg_write_d = 1'b1;
            S_MEM_ADDR: begin
                sel_mux2_d = 1'b1;  sel_mux4_d = 2'b10;  alu_op_d = 3'b001;
                load_aluout_d = 1'b1;
            end
            S_LD_WAIT: begin
                mem_read_d = 1'b1;  load_memdata_d = (cnt_d == WAIT_LAST);
            end
            S_LD_WB: begin
                reg_write_d = 1'b1;  sel_mem_d = 3'b001;
            end
            S_ST:     mem_wr_d = 1'b1;
            S_BRANCH: begin
                sel_mux2_d = 1'b1;  alu_op_d = 3'b010;
            end
            S_LUI: begin
                reg_write_d = 1'b1;  sel_mem_d = 3'b010;
            end
            S_JAL: begin
                sel_mux4_d = 2'b01;  alu_op_d = 3'b001;  reg_write_d = 1'b1;
                sel_mem_d = 3'b100;  pc_write_d = 1'b1;  sel_pc_d = 1'b1;
            end
            S_PC_INC: begin
                sel_mux4_d = 2'b01;  alu_op_d = 3'b001;  pc_write_d = 1'b1;
            end
`ifdef TRAP_ILLEGAL_EN
            S_ILLEGAL: trap_d = 1'b0;
            S_TRAP:    trap_d = 1'b1;
`else
            S_ILLEGAL: begin
                sel_mux4_d = 2'b01;  alu_op_d = 3'b001;  pc_write_d = 1'b1;
            end
            S_TRAP:    trap_d = 1'b0;
`endif
            default:   trap_d = 1'b0;
        endcase
    end

    // State, wait counter and registered strobes; reset clears them at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RESET;  cnt_q <= 3'd0;
            pc_write_q <= 1'b0;  sel_pc_q <= 1'b0;  load_ir_q <= 1'b0;  reg_write_q <= 1'b0;
            load_a_q <= 1'b0;  load_b_q <= 1'b0;  load_aluout_q <= 1'b0;
            load_memdata_q <= 1'b0;  mem_read_q <= 1'b0;  mem_wr_q <= 1'b0;
            sel_mux2_q <= 1'b0;  sel_mux4_q <= 2'b00;  sel_mem_q <= 3'b000;
            alu_op_q <= 3'b000;  trap_q <= 1'b0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;
            pc_write_q <= pc_write_d;  sel_pc_q <= sel_pc_d;  load_ir_q <= load_ir_d;
            reg_write_q <= reg_write_d;  load_a_q <= load_a_d;  load_b_q <= load_b_d;
            load_aluout_q <= load_aluout_d;  load_memdata_q <= load_memdata_d;
            mem_read_q <= mem_read_d;  mem_wr_q <= mem_wr_d;  sel_mux2_q <= sel_mux2_d;
            sel_mux4_q <= sel_mux4_d;  sel_mem_q <= sel_mem_d;  alu_op_q <= alu_op_d;
            trap_q <= trap_d;
        end
    end

    // The branch decision needs AluIgual from the BRANCH cycle itself, so the
    // taken PC load is merged in combinationally from the registered state.
    assign PCwrite        = pc_write_q | ((state_q == S_BRANCH) & taken_s);
    assign SelMuxPC       = sel_pc_q   | ((state_q == S_BRANCH) & taken_s);
    assign LoadIR         = load_ir_q;
    assign RegWrite       = reg_write_q;
    assign loadRegA       = load_a_q;
    assign loadRegB       = load_b_q;
    assign loadRegAluOut  = load_aluout_q;
    assign loadRegMemData = load_memdata_q;
    assign MemData_Read   = mem_read_q;
    assign MemWr          = mem_wr_q;
    assign SelMux2        = sel_mux2_q;
    assign SelMux4        = sel_mux4_q;
    assign SelMuxMem      = sel_mem_q;
    assign AluOperation   = alu_op_q;
    assign trap           = trap_q;
    assign estado         = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: each instruction is expanded by a
// per-instruction reference model into its cycle-by-cycle strobe sequence,
// queued, and a negedge monitor pops and compares one entry per cycle.
`timescale 1ns/1ps
module tb_controle_multiciclo;
    localparam int W = 2;
    localparam logic [19:0] ZERO = 20'd0;

    logic clk = 1'b0;
    logic rst;
    logic [6:0] i6_0;
    logic [2:0] i14_12;
    logic [6:0] i31_25;
    logic AluIgual;
    logic PCwrite, SelMuxPC, LoadIR, RegWrite, loadRegA, loadRegB, loadRegAluOut;
    logic loadRegMemData, MemData_Read, MemWr, SelMux2, trap;
    logic [1:0] SelMux4;
    logic [2:0] SelMuxMem, AluOperation;
    logic [4:0] estado;

    controle_multiciclo #(.MEM_WAIT(W)) dut (
        .clk(clk), .rst(rst), .i6_0(i6_0), .i14_12(i14_12), .i31_25(i31_25),
        .AluIgual(AluIgual), .PCwrite(PCwrite), .SelMuxPC(SelMuxPC), .LoadIR(LoadIR),
        .RegWrite(RegWrite), .loadRegA(loadRegA), .loadRegB(loadRegB),
        .loadRegAluOut(loadRegAluOut), .loadRegMemData(loadRegMemData),
        .MemData_Read(MemData_Read), .MemWr(MemWr), .SelMux2(SelMux2),
        .SelMux4(SelMux4), .SelMuxMem(SelMuxMem), .AluOperation(AluOperation),
        .trap(trap), .estado(estado)
    );

    always #5 clk = ~clk;

    logic [19:0] exp_q[$];
    logic [19:0] seq_q[$];
    logic [19:0] mon_exp;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
`ifdef TRAP_ILLEGAL_EN
    bit allow_illegal = 1'b0;
`else
    bit allow_illegal = 1'b1;
`endif

    function automatic logic [19:0] pack_out();
        return {PCwrite, SelMuxPC, LoadIR, RegWrite, loadRegA, loadRegB, loadRegAluOut,
                loadRegMemData, MemData_Read, MemWr, SelMux2, SelMux4, SelMuxMem,
                AluOperation, trap};
    endfunction

    // strobes = {PCwrite,SelMuxPC,LoadIR,RegWrite,lA,lB,lAluOut,lMemData,MemRead,MemWr}
    function automatic logic [19:0] v(input logic [9:0] st, input logic s2,
                                      input logic [1:0] s4, input logic [2:0] sm,
                                      input logic [2:0] op, input logic tr);
        return {st, s2, s4, sm, op, tr};
    endfunction

    // Reference model: expected strobe sequence of one whole instruction
    function automatic void model(input logic [31:0] ir, input logic eq);
        logic [19:0] pc_inc;
        logic [6:0] opc;
        logic [2:0] f3;
        bit is_r, illegal, taken;
        int op;
        pc_inc = v(10'b1000000000, 1'b0, 2'b01, 3'b000, 3'b001, 1'b0);
        opc = ir[6:0];
        f3 = ir[14:12];
        illegal = 1'b0;
        seq_q.delete();
        for (int k = 0; k < W; k++) seq_q.push_back(ZERO);
        seq_q.push_back(v(10'b0010000000, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0));
        seq_q.push_back(v(10'b0000111000, 1'b0, 2'b11, 3'b000, 3'b001, 1'b0));
        case (opc)
            7'b0110011, 7'b0010011: begin
                is_r = (opc == 7'b0110011);
                if (f3 == 3'b000) op = (is_r && ir[30]) ? 2 : 1;
                else if (f3 == 3'b111) op = 3;
                else if (f3 == 3'b100) op = 4;
                else if (f3 == 3'b110) op = 5;
                else op = 0;
                seq_q.push_back(v(10'b0000001000, 1'b1, is_r ? 2'b00 : 2'b10, 3'b000,
                                  3'(op), 1'b0));
                if (op == 0) illegal = 1'b1;
                else begin
                    seq_q.push_back(v(10'b0001000000, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0));
                    seq_q.push_back(pc_inc);
                end
            end
            7'b0000011: begin
                seq_q.push_back(v(10'b0000001000, 1'b1, 2'b10, 3'b000, 3'b001, 1'b0));
                for (int k = 0; k < W; k++)
                    seq_q.push_back(v(10'b0000000010, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0));
                seq_q.push_back(v(10'b0000000110, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0));
                seq_q.push_back(v(10'b0001000000, 1'b0, 2'b00, 3'b001, 3'b000, 1'b0));
                seq_q.push_back(pc_inc);
            end
            7'b0100011: begin
                seq_q.push_back(v(10'b0000001000, 1'b1, 2'b10, 3'b000, 3'b001, 1'b0));
                seq_q.push_back(v(10'b0000000001, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0));
                seq_q.push_back(pc_inc);
            end
            7'b1100011: begin
                taken = (f3 == 3'b000 && eq) || (f3 == 3'b001 && !eq);
                seq_q.push_back(v(taken ? 10'b1100000000 : 10'b0000000000, 1'b1, 2'b00,
                                  3'b000, 3'b010, 1'b0));
                if (f3 != 3'b000 && f3 != 3'b001) illegal = 1'b1;
                else if (!taken) seq_q.push_back(pc_inc);
            end
            7'b0110111: begin
                seq_q.push_back(v(10'b0001000000, 1'b0, 2'b00, 3'b010, 3'b000, 1'b0));
                seq_q.push_back(pc_inc);
            end
            7'b1101111:
                seq_q.push_back(v(10'b1101000000, 1'b0, 2'b01, 3'b100, 3'b001, 1'b0));
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
`ifdef TRAP_ILLEGAL_EN
            seq_q.push_back(ZERO);
            for (int k = 0; k < 20; k++) seq_q.push_back(20'd1);
`else
            seq_q.push_back(pc_inc);
`endif
        end
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] w;
        logic [6:0] opc;
        int k;
        k = $urandom_range(0, 8);
        case (k)
            0, 8: opc = 7'b0110011;
            1: opc = 7'b0010011;
            2: opc = 7'b0000011;
            3: opc = 7'b0100011;
            4: opc = 7'b1100011;
            5: opc = 7'b0110111;
            6: opc = 7'b1101111;
            default: begin
                opc = 7'($urandom);
                while (opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                   7'b1100011, 7'b0110111, 7'b1101111})
                    opc = 7'($urandom);
            end
        endcase
        w = $urandom;
        w[6:0] = opc;
        if ($urandom_range(0, 3) != 0) w[31:25] = {1'b0, w[30], 5'b00000};
        return w;
    endfunction

    task automatic do_cycle();
        @(posedge clk);
        #1;
    endtask

    // Push the expected sequence (first m entries, or all if m==0) and drive it
    task automatic run_instr(input logic [31:0] ir, input logic eq, input int m);
        int n;
        model(ir, eq);
        n = (m == 0) ? seq_q.size() : m;
        for (int k = 0; k < n; k++) exp_q.push_back(seq_q[k]);
        repeat (W) do_cycle();
        do_cycle();
        i6_0 = ir[6:0];
        i14_12 = ir[14:12];
        i31_25 = ir[31:25];
        AluIgual = eq;
        repeat (n - (W + 1)) do_cycle();
    endtask

    task automatic check_reset(input string name);
        n_vec++;
        if (pack_out() !== ZERO) begin
            n_err++;
            $display("FAIL %s: outputs got %b, expected %b", name, pack_out(), ZERO);
        end
    endtask

    task automatic release_rst();
        rst = 1'b1;
        exp_q.push_back(ZERO);
        mon_en = 1'b1;
        do_cycle();
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected cycles left, expected 0", name, exp_q.size());
        end
    endtask

    // Monitor: one expected strobe vector per clock cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_en) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL underflow at cycle %0d: got %b, no expected entry", cyc, pack_out());
            end else begin
                mon_exp = exp_q.pop_front();
                if (pack_out() !== mon_exp) begin
                    n_err++;
                    $display("FAIL strobes at cycle %0d: got %b, expected %b", cyc,
                             pack_out(), mon_exp);
                end
            end
        end
    end

    initial begin
        logic [31:0] ir;
        logic eq;
        rst = 1'b0;
        i6_0 = 7'd0;
        i14_12 = 3'd0;
        i31_25 = 7'd0;
        AluIgual = 1'b0;
        repeat (2) do_cycle();
        check_reset("reset_init");
        release_rst();

        run_instr(32'h002081B3, 1'b0, 0);
        run_instr(32'h0080B283, 1'b0, 0);
        run_instr(32'h00000463, 1'b1, 0);
        run_instr(32'h00000463, 1'b0, 0);
        run_instr(32'h0050B823, 1'b0, 0);
        run_instr(32'h00001463, 1'b1, 0);
        run_instr(32'h00001463, 1'b0, 0);
        run_instr(32'h40208233, 1'b0, 0);
        run_instr(32'h00000537, 1'b0, 0);
        run_instr(32'h0000006F, 1'b0, 0);
        if (allow_illegal) run_instr(32'h00002463, 1'b1, 0);

        for (int t = 0; t < 40; t++) begin
            eq = 1'($urandom);
            ir = rand_ir();
            model(ir, eq);
            while (!allow_illegal && seq_q[seq_q.size() - 1][0]) begin
                ir = rand_ir();
                model(ir, eq);
            end
            run_instr(ir, eq, 0);
        end

        run_instr(32'h0080B283, 1'b0, W + 4);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check_reset("reset_mid_ld_wait");
        check_drained("queue_at_reset");
        do_cycle();
        check_reset("reset_held");
        release_rst();

        run_instr(32'hFFFFFFFF, 1'b0, 0);
`ifndef TRAP_ILLEGAL_EN
        exp_q.push_back(ZERO);
        do_cycle();
`endif
        mon_en = 1'b0;
        check_drained("queue_at_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
